// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM layer blocks.
//   LSTM_DATA_WIDTH  : default fixed-point word width (signed, two's complement)
//   LSTM_FRACT_WIDTH : default number of fractional bits in a word
//   lstm_seq_state_t : states of the timestep sequencer (lstm_seq_ctrl)
package lstm_pkg;

    localparam int LSTM_DATA_WIDTH  = 16;
    localparam int LSTM_FRACT_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT_X = 3'd1,
        SETTLE = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } lstm_seq_state_t;

endpackage

// File: rtl/lstm_seq_ctrl.sv
// Timestep sequencer for a single combinational lstm_cell.
// Streams X samples through the cell one step at a time, feeding the captured
// c/h back as the next step's c_in/h_in, and emits each step's hidden state on
// a valid/ready stream.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, seq_len, c0, h0 sequence launch (sampled only in IDLE)
//   abort                  cancel the running sequence, back to IDLE
//   x_valid/x_ready/x_data input sample stream
//   cell_x/cell_c/cell_h   registered operands driven to the cell
//   cell_c_out/cell_h_out  cell results, captured after SETTLE_CYC cycles
//   h_valid/h_ready/h_data/h_last  per-step hidden-state output stream
//   busy, done             status; done pulses once per completed sequence
//   c_final, h_final       last captured c/h, held until the next start
module lstm_seq_ctrl
    import lstm_pkg::*;
#(
    parameter int DATA_WIDTH  = LSTM_DATA_WIDTH,
    parameter int FRACT_WIDTH = LSTM_FRACT_WIDTH,
    parameter int LEN_W       = 8,
    parameter int SETTLE_CYC  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      seq_len,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] c0,
    input  logic [DATA_WIDTH-1:0] h0,
    input  logic                  x_valid,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic                  x_ready,
    output logic [DATA_WIDTH-1:0] cell_x,
    output logic [DATA_WIDTH-1:0] cell_c,
    output logic [DATA_WIDTH-1:0] cell_h,
    input  logic [DATA_WIDTH-1:0] cell_c_out,
    input  logic [DATA_WIDTH-1:0] cell_h_out,
    output logic                  h_valid,
    output logic [DATA_WIDTH-1:0] h_data,
    output logic                  h_last,
    input  logic                  h_ready,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] c_final,
    output logic [DATA_WIDTH-1:0] h_final
);

    // Counter only has to hold SETTLE_CYC-1 down to 0.
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    if (SETTLE_CYC < 1) begin : g_bad_settle
        $error("lstm_seq_ctrl: SETTLE_CYC must be at least 1");
    end
    if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
        $error("lstm_seq_ctrl: FRACT_WIDTH must be smaller than DATA_WIDTH");
    end

    lstm_seq_state_t       state_q, state_d;
    logic [DATA_WIDTH-1:0] x_q, x_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic [DATA_WIDTH-1:0] h_q, h_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      step_q, step_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  x_ready_q, h_valid_q, h_last_q, busy_q, done_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        c_d     = c_q;
        h_d     = h_q;
        len_d   = len_q;
        step_d  = step_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    c_d     = c0;
                    h_d     = h0;
                    len_d   = seq_len;
                    step_d  = '0;
                    state_d = (seq_len != '0) ? WAIT_X : DONE;
                end
            end
            WAIT_X: begin
                if (x_valid) begin
                    x_d     = x_data;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Cell inputs have been stable for SETTLE_CYC cycles once cnt hits 0.
                if (cnt_q == '0) begin
                    c_d     = cell_c_out;
                    h_d     = cell_h_out;
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            EMIT: begin
                if (h_ready) begin
                    step_d  = step_q + 1'b1;
                    state_d = h_last_q ? DONE : WAIT_X;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort discards whatever this cycle would have captured; c/h keep their values.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            x_d     = x_q;
            c_d     = c_q;
            h_d     = h_q;
            len_d   = len_q;
            step_d  = step_q;
            cnt_d   = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= '0;
            c_q       <= '0;
            h_q       <= '0;
            len_q     <= '0;
            step_q    <= '0;
            cnt_q     <= '0;
            x_ready_q <= 1'b0;
            h_valid_q <= 1'b0;
            h_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            c_q       <= c_d;
            h_q       <= h_d;
            len_q     <= len_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            // Status flags are registered from the next state so they line up with state_q.
            x_ready_q <= (state_d == WAIT_X);
            h_valid_q <= (state_d == EMIT);
            h_last_q  <= (state_d == EMIT) && (step_d == len_d - 1'b1);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
        end
    end

    assign x_ready = x_ready_q;
    assign h_valid = h_valid_q;
    assign h_last  = h_last_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cell_x  = x_q;
    assign cell_c  = c_q;
    assign cell_h  = h_q;
    assign c_final = c_q;
    assign h_final = h_q;
    assign h_data  = h_q;

endmodule
